// File: rtl/tester_pkg.sv
// Shared speed-test header definitions used by the frame filter, checker and generator.
package tester_pkg;

  localparam logic [15:0] TEST_ETHERTYPE = 16'h88B5;
  localparam logic [31:0] TEST_MAGIC     = 32'h5441_4E4C;

  localparam int unsigned ETHERTYPE_OFS   = 12;
  localparam int unsigned MAGIC_OFS       = 14;
  localparam int unsigned MIN_HDR_BYTES   = 18;
  // Bytes from the EtherType up to the end of the magic word
  localparam int unsigned HDR_MATCH_BYTES = MIN_HDR_BYTES - ETHERTYPE_OFS;

endpackage

// File: rtl/test_frame_classifier.sv
// Combinational first-beat match: EtherType + magic present, header bytes all kept, enable set.
module test_frame_classifier
  import tester_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = TEST_ETHERTYPE,
  parameter logic [31:0] MAGIC     = TEST_MAGIC
) (
  input  logic [HDR_MATCH_BYTES*8-1:0] hdr_i,
  input  logic [MIN_HDR_BYTES-1:0]     keep_i,
  input  logic                         enable_i,
  output logic                         is_test_c
);

  localparam logic [HDR_MATCH_BYTES*8-1:0] HDR_BE = {ETHERTYPE, MAGIC};

  logic [HDR_MATCH_BYTES*8-1:0] hdr_exp_c;

  // hdr_i byte 0 is the first byte on the wire, so the big-endian constant is byte-reversed
  always_comb begin
    hdr_exp_c = '0;
    for (int unsigned i = 0; i < HDR_MATCH_BYTES; i++) begin
      hdr_exp_c[i*8 +: 8] = HDR_BE[(HDR_MATCH_BYTES-1-i)*8 +: 8];
    end
  end

  assign is_test_c = enable_i & (&keep_i) & (hdr_i == hdr_exp_c);

endmodule

// File: rtl/test_frame_filter.sv
// Steers whole AXIS frames to the test (checker) or bypass output via one registered stage.
// Optional: TEST_FRAME_FILTER_STATS_EN adds test/other frame counters on the stats port.
module test_frame_filter
  import tester_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ID_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic [63:0]             stats,

  input  logic [DATA_WIDTH-1:0]   axis_s_data,
  input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
  input  logic                    axis_s_last,
  input  logic [DATA_WIDTH/8-1:0] axis_s_user,
  input  logic [ID_WIDTH-1:0]     axis_s_id,
  input  logic                    axis_s_valid,
  output logic                    axis_s_ready,

  output logic [DATA_WIDTH-1:0]   axis_t_data,
  output logic [DATA_WIDTH/8-1:0] axis_t_keep,
  output logic                    axis_t_last,
  output logic [DATA_WIDTH/8-1:0] axis_t_user,
  output logic [ID_WIDTH-1:0]     axis_t_id,
  output logic                    axis_t_valid,
  input  logic                    axis_t_ready,

  output logic [DATA_WIDTH-1:0]   axis_b_data,
  output logic [DATA_WIDTH/8-1:0] axis_b_keep,
  output logic                    axis_b_last,
  output logic [DATA_WIDTH/8-1:0] axis_b_user,
  output logic [ID_WIDTH-1:0]     axis_b_id,
  output logic                    axis_b_valid,
  input  logic                    axis_b_ready
);

  localparam int unsigned KEEP_W = DATA_WIDTH / 8;

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_BODY  = 1'b1;

  if (DATA_WIDTH < MIN_HDR_BYTES * 8) begin : g_bad_width
    $error("test_frame_filter: DATA_WIDTH too small for the test header");
  end

  logic [0:0]            state_q, state_d;
  logic                  dest_lat_q, dest_lat_d;
  logic                  buf_valid_q, buf_valid_d;
  logic                  buf_dest_q, buf_dest_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [KEEP_W-1:0]     buf_keep_q, buf_keep_d;
  logic                  buf_last_q, buf_last_d;
  logic [KEEP_W-1:0]     buf_user_q, buf_user_d;
  logic [ID_WIDTH-1:0]   buf_id_q, buf_id_d;

  logic is_test_c, sel_ready_c, s_ready_c, accept_c, beat_dest_c, first_c;

  test_frame_classifier u_classifier (
    .hdr_i     (axis_s_data[ETHERTYPE_OFS*8 +: HDR_MATCH_BYTES*8]),
    .keep_i    (axis_s_keep[MIN_HDR_BYTES-1:0]),
    .enable_i  (enable),
    .is_test_c (is_test_c)
  );

  // Ready looks only at the buffer and the sink it is aimed at, never at the input payload
  always_comb begin
    sel_ready_c = buf_dest_q ? axis_t_ready : axis_b_ready;
    s_ready_c   = ~buf_valid_q | sel_ready_c;
    accept_c    = axis_s_valid & s_ready_c;
    first_c     = (state_q == ST_FIRST);
    beat_dest_c = first_c ? is_test_c : dest_lat_q;
  end

  always_comb begin
    state_d     = state_q;
    dest_lat_d  = dest_lat_q;
    buf_valid_d = buf_valid_q;
    buf_dest_d  = buf_dest_q;
    buf_data_d  = buf_data_q;
    buf_keep_d  = buf_keep_q;
    buf_last_d  = buf_last_q;
    buf_user_d  = buf_user_q;
    buf_id_d    = buf_id_q;
    if (accept_c) begin
      state_d     = axis_s_last ? ST_FIRST : ST_BODY;
      dest_lat_d  = beat_dest_c;
      buf_valid_d = 1'b1;
      buf_dest_d  = beat_dest_c;
      buf_data_d  = axis_s_data;
      buf_keep_d  = axis_s_keep;
      buf_last_d  = axis_s_last;
      buf_user_d  = axis_s_user;
      buf_id_d    = axis_s_id;
    end else if (buf_valid_q && sel_ready_c) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FIRST;
      dest_lat_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_dest_q  <= 1'b0;
      buf_data_q  <= '0;
      buf_keep_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_user_q  <= '0;
      buf_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      dest_lat_q  <= dest_lat_d;
      buf_valid_q <= buf_valid_d;
      buf_dest_q  <= buf_dest_d;
      buf_data_q  <= buf_data_d;
      buf_keep_q  <= buf_keep_d;
      buf_last_q  <= buf_last_d;
      buf_user_q  <= buf_user_d;
      buf_id_q    <= buf_id_d;
    end
  end

  assign axis_s_ready = s_ready_c;

  assign axis_t_valid = buf_valid_q & buf_dest_q;
  assign axis_t_data  = buf_data_q;
  assign axis_t_keep  = buf_keep_q;
  assign axis_t_last  = buf_last_q;
  assign axis_t_user  = buf_user_q;
  assign axis_t_id    = buf_id_q;

  assign axis_b_valid = buf_valid_q & ~buf_dest_q;
  assign axis_b_data  = buf_data_q;
  assign axis_b_keep  = buf_keep_q;
  assign axis_b_last  = buf_last_q;
  assign axis_b_user  = buf_user_q;
  assign axis_b_id    = buf_id_q;

`ifdef TEST_FRAME_FILTER_STATS_EN
  logic [31:0] test_cnt_q, test_cnt_d;
  logic [31:0] other_cnt_q, other_cnt_d;

  // Counted once per frame, on its accepted first beat
  always_comb begin
    test_cnt_d  = test_cnt_q;
    other_cnt_d = other_cnt_q;
    if (accept_c && first_c) begin
      if (is_test_c) test_cnt_d  = test_cnt_q + 32'd1;
      else           other_cnt_d = other_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_cnt_q  <= '0;
      other_cnt_q <= '0;
    end else begin
      test_cnt_q  <= test_cnt_d;
      other_cnt_q <= other_cnt_d;
    end
  end

  assign stats = {test_cnt_q, other_cnt_q};
`else
  assign stats = 64'h0;
`endif

endmodule
